// File: rtl/encrypt_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_frame_ctrl
// Description : Runs one image frame through the XOR pixel encryptor. Each
//               pixel byte is paired with exactly one key byte. The XOR result
//               is held in a registered valid/ready output stage. The block
//               counts pixels up to frame end, then pulses done. It also flags
//               a key stream that stops delivering bytes (key starvation).
// Revision    : 1.0  initial release
// ============================================================================
module encrypt_frame_ctrl #(
  parameter int FRAME_LEN   = 786432,
  parameter int CNT_W       = 20,
  parameter int KEY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       pix_in_data,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  input  logic [7:0]       key_tdata,
  input  logic             key_tvalid,
  output logic             key_tready,
  output logic [7:0]       enc_data,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic             busy,
  output logic             done,
  output logic             key_err,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The starvation counter only has to reach KEY_TIMEOUT-1.
  localparam int             TO_W     = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
  localparam bit             TO_EN    = (KEY_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((KEY_TIMEOUT > 0) ? KEY_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            out_free;
  logic            fire;
  logic            last_fire;
  logic            starve;
  logic            timeout_hit;
  logic            start_ok;

  // Handshake and event terms shared by the FSM and the datapath.
  // A pixel and a key move only together. Each ready is qualified by the other
  // stream's valid, so neither byte can be consumed alone.
  always_comb begin
    out_free    = !enc_valid | enc_ready;
    fire        = pix_in_valid & key_tvalid & (state == S_RUN) & out_free;
    last_fire   = fire & (pix_count == LAST_IDX);
    starve      = pix_in_valid & !key_tvalid;
    timeout_hit = TO_EN & (state == S_RUN) & starve & (to_cnt == TO_LAST);
    start_ok    = (state == S_IDLE) & start & !abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. Abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN: begin
          if (timeout_hit)    state_nxt = S_IDLE;
          else if (last_fire) state_nxt = S_DRAIN;
        end
        S_DRAIN: if (out_free) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    pix_in_ready = (state == S_RUN) & key_tvalid & out_free;
    key_tready   = (state == S_RUN) & pix_in_valid & out_free;
    busy         = (state == S_RUN) | (state == S_DRAIN);
    done         = (state == S_DONE);
  end

  // Output register, pixel counter and sticky starvation flag.
  // An abort drops any pending byte but keeps the count and the error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enc_data  <= '0;
      enc_valid <= 1'b0;
      key_err   <= 1'b0;
      pix_count <= '0;
    end else if (abort) begin
      enc_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        pix_count <= '0;
        key_err   <= 1'b0;
      end
      if (fire) begin
        enc_data  <= pix_in_data ^ key_tdata;
        enc_valid <= 1'b1;
        if (pix_count != CNT_FULL) pix_count <= pix_count + 1'b1;
      end else if (timeout_hit) begin
        enc_valid <= 1'b0;
        key_err   <= 1'b1;
      end else if (enc_ready) begin
        enc_valid <= 1'b0;
      end
    end
  end

  // Key-starvation counter. It counts consecutive RUN cycles in which a pixel
  // waits with no key available, and it clears on any other cycle.
  always_ff @(posedge clk) begin
    if (!rst)
      to_cnt <= '0;
    else if (TO_EN && (state == S_RUN) && starve && !abort && !timeout_hit)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_encrypt_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_frame_ctrl
// Description : Self-checking bench for encrypt_frame_ctrl. It combines a
//               vector table, hand-written corner sequences and random frames
//               checked against a byte-order scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_encrypt_frame_ctrl;

  localparam int FRAME_LEN   = 8;
  localparam int CNT_W       = 4;
  localparam int KEY_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [7:0]       pix_in_data, key_tdata;
  logic             pix_in_valid, key_tvalid, enc_ready;
  logic             pix_in_ready, key_tready, enc_valid, busy, done, key_err;
  logic [7:0]       enc_data;
  logic [CNT_W-1:0] pix_count;

  int tests = 0;
  int fails = 0;

  encrypt_frame_ctrl #(
    .FRAME_LEN  (FRAME_LEN),
    .CNT_W      (CNT_W),
    .KEY_TIMEOUT(KEY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pix_in_data (pix_in_data),
    .pix_in_valid(pix_in_valid),
    .pix_in_ready(pix_in_ready),
    .key_tdata   (key_tdata),
    .key_tvalid  (key_tvalid),
    .key_tready  (key_tready),
    .enc_data    (enc_data),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .busy        (busy),
    .done        (done),
    .key_err     (key_err),
    .pix_count   (pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             s;
    logic             pv;
    logic [7:0]       pd;
    logic             kv;
    logic [7:0]       kd;
    logic             er;
    logic             x_pir;
    logic             x_ev;
    logic [7:0]       x_ed;
    logic             x_done;
    logic             x_busy;
    logic [CNT_W-1:0] x_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkv(input logic s, input logic pv, input logic [7:0] pd,
                               input logic kv, input logic [7:0] kd, input logic er,
                               input logic xpir, input logic xev, input logic [7:0] xed,
                               input logic xdone, input logic xbusy, input logic [CNT_W-1:0] xcnt);
    vec_t v;
    v.s = s; v.pv = pv; v.pd = pd; v.kv = kv; v.kd = kd; v.er = er;
    v.x_pir = xpir; v.x_ev = xev; v.x_ed = xed; v.x_done = xdone;
    v.x_busy = xbusy; v.x_cnt = xcnt;
    return v;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic a, input logic pv, input logic [7:0] pd,
                        input logic kv, input logic [7:0] kd, input logic er);
    start = s; abort = a; pix_in_valid = pv; pix_in_data = pd;
    key_tvalid = kv; key_tdata = kd; enc_ready = er;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " enc_data"},     enc_data,     0);
    check({tag, " enc_valid"},    enc_valid,    0);
    check({tag, " done"},         done,         0);
    check({tag, " key_err"},      key_err,      0);
    check({tag, " pix_count"},    pix_count,    0);
    check({tag, " busy"},         busy,         0);
    check({tag, " pix_in_ready"}, pix_in_ready, 0);
    check({tag, " key_tready"},   key_tready,   0);
  endtask

  // Random frame with a scoreboard: the bytes must come out in order as
  // pix[i]^key[i]. Pixel and key must be consumed together. A stalled output
  // must hold. done must come exactly once, after the last byte.
  // mode 0: random enc_ready, mode 1: enc_ready toggling.
  task automatic run_frame(input int mode);
    logic [7:0] pix[FRAME_LEN];
    logic [7:0] key[FRAME_LEN];
    int p = 0, k = 0, o = 0, streak = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic seen_done = 1'b0;
    logic pfire, kfire;
    for (int i = 0; i < FRAME_LEN; i++) begin
      pix[i] = 8'($urandom);
      key[i] = 8'($urandom);
    end
    for (int cy = 0; cy < 400 && !seen_done; cy++) begin
      @(negedge clk);
      start = (cy == 0);
      abort = 1'b0;
      pix_in_valid = (p < FRAME_LEN) && ($urandom_range(3) != 0);
      if (p < FRAME_LEN) pix_in_data = pix[p];
      else               pix_in_data = 8'($urandom);
      key_tvalid = ($urandom_range(1) != 0);
      // Keep starvation runs short so the timeout never triggers here.
      if (pix_in_valid && streak >= 2) key_tvalid = 1'b1;
      if (k < FRAME_LEN) key_tdata = key[k];
      else               key_tdata = 8'($urandom);
      if (mode == 1) enc_ready = cy[0];
      else           enc_ready = ($urandom_range(2) != 0);
      #1;
      if (pix_in_valid && !key_tvalid) streak++;
      else                             streak = 0;
      pfire = pix_in_valid & pix_in_ready;
      kfire = key_tvalid & key_tready;
      check("RND paired consume", pfire, kfire);
      if (prev_stall) begin
        check("RND stalled valid held", enc_valid, 1);
        check("RND stalled data held", enc_data, prev_data);
      end
      if (enc_valid && enc_ready) begin
        if (o < FRAME_LEN) check($sformatf("RND byte %0d", o), enc_data, pix[o] ^ key[o]);
        else               check("RND extra output byte", o + 1, FRAME_LEN);
        o++;
      end
      if (done) begin
        check("RND done after all bytes", o, FRAME_LEN);
        seen_done = 1'b1;
      end
      prev_stall = enc_valid & !enc_ready;
      prev_data  = enc_data;
      if (pfire) p++;
      if (kfire) k++;
    end
    check("RND frame finished in budget", seen_done, 1);
    check("RND final pix_count", pix_count, FRAME_LEN);
    check("RND key_err clear", key_err, 0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #1;
    check("RND done single pulse", done, 0);
    check("RND idle after frame", busy, 0);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Full-throughput frame: pixels 0..7 with key 0xA5.
    vecs[0]  = mkv(1'b1, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    vecs[1]  = mkv(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
    vecs[2]  = mkv(1'b0, 1'b1, 8'h01, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 4'd1);
    vecs[3]  = mkv(1'b0, 1'b1, 8'h02, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b0, 1'b1, 4'd2);
    vecs[4]  = mkv(1'b0, 1'b1, 8'h03, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b1, 4'd3);
    vecs[5]  = mkv(1'b0, 1'b1, 8'h04, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA6, 1'b0, 1'b1, 4'd4);
    vecs[6]  = mkv(1'b0, 1'b1, 8'h05, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd5);
    vecs[7]  = mkv(1'b0, 1'b1, 8'h06, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 4'd6);
    vecs[8]  = mkv(1'b0, 1'b1, 8'h07, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 4'd7);
    vecs[9]  = mkv(1'b0, 1'b1, 8'h55, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 4'd8);
    vecs[10] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b1, 1'b0, 4'd8);
    vecs[11] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 4'd8);

    // T1: reset held with random inputs.
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), 8'($urandom), 1'($urandom));
      #1;
      check_zero($sformatf("T1 reset c%0d", i));
    end
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // T2: table-driven full-rate frame.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vecs[i].s, 1'b0, vecs[i].pv, vecs[i].pd, vecs[i].kv, vecs[i].kd, vecs[i].er);
      #1;
      check($sformatf("T2 r%0d pix_in_ready", i), pix_in_ready, vecs[i].x_pir);
      check($sformatf("T2 r%0d key_tready", i),   key_tready,   vecs[i].x_pir);
      check($sformatf("T2 r%0d enc_valid", i),    enc_valid,    vecs[i].x_ev);
      check($sformatf("T2 r%0d enc_data", i),     enc_data,     vecs[i].x_ed);
      check($sformatf("T2 r%0d done", i),         done,         vecs[i].x_done);
      check($sformatf("T2 r%0d busy", i),         busy,         vecs[i].x_busy);
      check($sformatf("T2 r%0d pix_count", i),    pix_count,    vecs[i].x_cnt);
      check($sformatf("T2 r%0d key_err", i),      key_err,      0);
    end

    // T3: backpressure, toggling then random.
    run_frame(1);
    run_frame(0);

    // T4: key starvation with KEY_TIMEOUT=4.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); set_in(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1); #1;
      check($sformatf("T4 c%0d busy", c), busy, 1);
      check($sformatf("T4 c%0d key_err not yet", c), key_err, 0);
      check($sformatf("T4 c%0d pix_in_ready", c), pix_in_ready, 0);
    end
    @(negedge clk); set_in(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h11, 1'b1); #1;
    check("T4 key_err set", key_err, 1);
    check("T4 back to idle", busy, 0);
    check("T4 no done", done, 0);
    check("T4 pix_in_ready low", pix_in_ready, 0);
    check("T4 key_tready low", key_tready, 0);
    check("T4 enc_valid low", enc_valid, 0);
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T4 key_err sticky", key_err, 1);
    check("T4 still no done", done, 0);
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T4 start clears key_err", key_err, 0);
    check("T4 restart busy", busy, 1);

    // T5: abort after three bytes (from the RUN state just entered).
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); set_in(1'b0, 1'b0, 1'b1, 8'(8'h10 + b), 1'b1, 8'hFF, 1'b1); #1;
      check($sformatf("T5 b%0d pix_in_ready", b), pix_in_ready, 1);
    end
    @(negedge clk); set_in(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T5 last byte visible", enc_valid, 1);
    check("T5 last byte data", enc_data, 8'hED);
    check("T5 count before abort", pix_count, 3);
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T5 idle after abort", busy, 0);
    check("T5 enc_valid cleared", enc_valid, 0);
    check("T5 pix_count held", pix_count, 3);
    check("T5 no done", done, 0);
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T5 no late done", done, 0);
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T5 restart count zero", pix_count, 0);
    check("T5 restart busy", busy, 1);

    // T6: start ignored in RUN, then start+abort in IDLE.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b1, 8'h42, 1'b1, 8'h24, 1'b1); #1;
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T6 start in RUN ignored count", pix_count, 1);
    check("T6 start in RUN busy", busy, 1);
    check("T6 byte data", enc_data, 8'h66);
    @(negedge clk); set_in(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    @(negedge clk); set_in(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T6 idle before start+abort", busy, 0);
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    check("T6 start+abort stays idle", busy, 0);
    check("T6 start+abort count held", pix_count, 1);

    // Reset in the middle of a frame discards it.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1); #1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); set_in(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 8'h01, 1'b0); #1;
    end
    @(negedge clk); rst = 1'b0;
    set_in(1'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1); #1;
    @(negedge clk); #1;
    check_zero("MID reset");
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // More random frames.
    for (int f = 0; f < 3; f++) run_frame(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
